// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer around an external 8-bit combinational ALU.
// Registers a command onto the ALU inputs, captures the result a cycle later, and queues it in a response FIFO.
module alu_issue_ctrl #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_use_acc,
  input  logic              acc_clr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [DATA_W-1:0] acc,
  output logic              busy
);
  localparam int          PW     = $clog2(DEPTH);
  localparam logic [PW:0] FULL   = (PW+1)'(DEPTH);
  localparam logic [3:0]  OP_CMP = 4'd8;

  typedef enum logic {IDLE, EXEC} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              carry;
    logic              zero;
    logic              err;
  } rsp_t;

  state_t          state, state_nxt;
  logic            err_q;
  rsp_t            mem [DEPTH];
  rsp_t            head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            accept, push, pop;

  // Held low through reset so nothing is accepted while the block is being cleared.
  assign cmd_ready = rst_n && (state == IDLE) && (count != FULL);
  assign accept    = cmd_valid && cmd_ready;
  assign push      = (state == EXEC);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = (count != '0);
  assign busy      = (state == EXEC) || (count != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      err_q   <= 1'b0;
      acc     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_a   <= cmd_use_acc ? acc : cmd_a;
        alu_b   <= cmd_b;
        alu_sel <= cmd_op;
        err_q   <= (cmd_op > OP_CMP);
      end
      // Clear takes priority over a same-cycle writeback.
      if (acc_clr)
        acc <= '0;
      else if (push && !err_q && (alu_sel != OP_CMP))
        acc <= alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{data: alu_result, carry: alu_carry, zero: alu_zero, err: err_q};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign rsp_data  = head.data;
  assign rsp_carry = head.carry;
  assign rsp_zero  = head.zero;
  assign rsp_err   = head.err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 8-bit ALU on the alu_* ports.
module tb_alu_issue_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [3:0] cmd_op = '0;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic       cmd_use_acc = 1'b0, acc_clr = 1'b0;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_sel;
  logic       alu_carry, alu_zero;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [7:0] rsp_data, acc;
  logic       rsp_carry, rsp_zero, rsp_err, busy;
  logic [8:0] alu_t;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DEPTH(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .acc_clr(acc_clr), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .acc(acc), .busy(busy)
  );

  // Carry on SUB/DEC/CMP is the borrow out of the 9-bit difference.
  always_comb begin
    alu_t = '0;
    case (alu_sel)
      4'd0: alu_t = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1: alu_t = {1'b0, alu_a} - {1'b0, alu_b};
      4'd2: alu_t = {1'b0, alu_a & alu_b};
      4'd3: alu_t = {1'b0, alu_a | alu_b};
      4'd4: alu_t = {1'b0, alu_a ^ alu_b};
      4'd5: alu_t = {1'b0, ~alu_a};
      4'd6: alu_t = {1'b0, alu_a} + 9'd1;
      4'd7: alu_t = {1'b0, alu_a} - 9'd1;
      4'd8: alu_t = {1'b0, alu_a} - {1'b0, alu_b};
      default: alu_t = '0;
    endcase
    alu_result = alu_t[7:0];
    alu_carry  = alu_t[8];
    alu_zero   = (alu_t[7:0] == 8'h00);
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offers a command and returns just after the edge that accepted it.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic ua);
    int n = 0;
    @(negedge clk);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("accept_timeout", {15'd0, cmd_ready}, 16'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  // Waits for a head entry, checks it, and pops it.
  task automatic expect_rsp(input string tag, input logic [7:0] d, input logic c,
                            input logic z, input logic e);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, {15'd0, rsp_valid}, 16'd1);
    chk({tag, "_data"}, {8'd0, rsp_data}, {8'd0, d});
    chk({tag, "_flags"}, {13'd0, rsp_carry, rsp_zero, rsp_err}, {13'd0, c, z, e});
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_cmd_ready", {15'd0, cmd_ready}, 16'd0);
    chk("rst_outs", {alu_a, alu_b}, 16'd0);
    chk("rst_sel_acc", {4'd0, alu_sel, acc}, 16'd0);
    chk("rst_rsp", {12'd0, rsp_valid, rsp_err, rsp_zero, busy}, 16'd0);
    @(negedge clk); rst_n = 1'b1;

    // 1: reset lands during EXEC -> command is dropped
    send(4'd0, 8'h01, 8'h02, 1'b0);
    @(negedge clk);
    chk("t1_busy_exec", {15'd0, busy}, 16'd1);
    rst_n = 1'b0; #1;
    chk("t1_alu_cleared", {alu_a, alu_b}, 16'd0);
    chk("t1_ctl_cleared", {10'd0, cmd_ready, rsp_valid, busy, rsp_data[0], rsp_carry, rsp_zero}, 16'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t1_no_rsp", {14'd0, rsp_valid, busy}, 16'd0);

    // 2: ADD with carry out
    send(4'd0, 8'hF0, 8'h20, 1'b0);
    @(negedge clk);
    chk("t2_alu_ops", {alu_a, alu_b}, 16'hF020);
    chk("t2_exec", {11'd0, alu_sel, cmd_ready, rsp_valid}, {11'd0, 4'd0, 1'b0, 1'b0});
    @(negedge clk);
    chk("t2_rsp_now", {15'd0, rsp_valid}, 16'd1);
    chk("t2_acc", {8'd0, acc}, 16'h0010);
    expect_rsp("t2", 8'h10, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_drained", {14'd0, rsp_valid, busy}, 16'd0);

    // 3: chained ADD then SUB from accumulator
    send(4'd0, 8'h05, 8'h03, 1'b0);
    send(4'd1, 8'hAA, 8'h08, 1'b1);
    @(negedge clk);
    chk("t3_alu_a_from_acc", {8'd0, alu_a}, 16'h0008);
    @(negedge clk);
    chk("t3_acc", {8'd0, acc}, 16'h0000);
    expect_rsp("t3a", 8'h08, 1'b0, 1'b0, 1'b0);
    expect_rsp("t3b", 8'h00, 1'b0, 1'b1, 1'b0);

    // 4: CMP and illegal opcode leave acc alone
    send(4'd0, 8'h11, 8'h22, 1'b0);
    expect_rsp("t4_seed", 8'h33, 1'b0, 1'b0, 1'b0);
    send(4'd8, 8'h5A, 8'h5A, 1'b0);
    expect_rsp("t4_cmp", 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t4_acc_cmp", {8'd0, acc}, 16'h0033);
    send(4'hC, 8'h12, 8'h34, 1'b0);
    expect_rsp("t4_ill", 8'h00, 1'b0, 1'b1, 1'b1);
    chk("t4_acc_ill", {8'd0, acc}, 16'h0033);

    // 5: backpressure, FIFO fills at 4
    send(4'd6, 8'h10, 8'h00, 1'b0);
    send(4'd6, 8'h20, 8'h00, 1'b0);
    send(4'd6, 8'h30, 8'h00, 1'b0);
    send(4'd6, 8'h40, 8'h00, 1'b0);
    @(negedge clk); @(negedge clk);
    cmd_op = 4'd6; cmd_a = 8'h50; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    chk("t5_full_ready", {14'd0, cmd_ready, busy}, 16'd1);
    chk("t5_acc", {8'd0, acc}, 16'h0041);
    chk("t5_head", {7'd0, rsp_valid, rsp_data}, {7'd0, 1'b1, 8'h11});
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("t5_ready_after_pop", {15'd0, cmd_ready}, 16'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    expect_rsp("t5_2", 8'h21, 1'b0, 1'b0, 1'b0);
    expect_rsp("t5_3", 8'h31, 1'b0, 1'b0, 1'b0);
    expect_rsp("t5_4", 8'h41, 1'b0, 1'b0, 1'b0);
    expect_rsp("t5_5", 8'h51, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("t5_no_dup", {14'd0, rsp_valid, busy}, 16'd0);

    // 6: acc_clr coincident with writeback
    send(4'd0, 8'h70, 8'h07, 1'b0);
    @(negedge clk); acc_clr = 1'b1;
    @(posedge clk); #1 acc_clr = 1'b0;
    @(negedge clk);
    chk("t6_acc_cleared", {8'd0, acc}, 16'h0000);
    chk("t6_rsp_data", {7'd0, rsp_valid, rsp_data}, {7'd0, 1'b1, 8'h77});
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
